// File: rtl/fpga_computer.sv
// SAP-1-class 8-bit/16-word computer with front-panel manual load/inspect and a run mode.
// Six-step T-state sequencer fetches from RAM and executes the IR[7:4] opcode.
module fpga_computer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] SEL,
    input  logic [7:0] PRGM_IN,
    input  logic       EN,
    input  logic       GO,
    input  logic       OE,
    input  logic       WE,
    input  logic       PRGM,
    input  logic       HLT,
    output logic [3:0] COUNT,
    output logic [7:0] BUS_OUT,
    output logic [7:0] CURRENT,
    output logic       ON
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} tstate_e;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
        OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
        OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    logic [3:0] pc_q, pc_d, mar_q, mar_d;
    logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d, bus_q, bus_d;
    logic       c_q, c_d, z_q, z_d, halted_q, halted_d, go_q;
    tstate_e    t_q, t_d;

    logic [7:0] ram [16];
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata, ram_rd;

    opcode_e    opc;
    logic       is_sub;
    logic [8:0] alu_sum;
    logic       wr;
    logic [7:0] wval;

    assign ram_rd = ram[mar_q];
    assign opc    = opcode_e'(ir_q[7:4]);
    assign is_sub = (opc == OP_SUB);
    // Subtract as A + ~B + 1 so bit 8 is the no-borrow flag.
    assign alu_sum = {1'b0, a_q} + {1'b0, (is_sub ? ~b_q : b_q)} + {8'b0, is_sub};

    always_comb begin
        case (SEL)
            4'd0:    CURRENT = {4'b0, pc_q};
            4'd1:    CURRENT = {4'b0, mar_q};
            4'd2:    CURRENT = ram_rd;
            4'd3:    CURRENT = ir_q;
            4'd4:    CURRENT = a_q;
            4'd5:    CURRENT = b_q;
            4'd6:    CURRENT = alu_sum[7:0];
            4'd7:    CURRENT = {6'b0, z_q, c_q};
            4'd8:    CURRENT = out_q;
            4'd9:    CURRENT = bus_q;
            4'd10:   CURRENT = {5'b0, t_q};
            default: CURRENT = '0;
        endcase
    end

    always_comb begin
        pc_d = pc_q;  mar_d = mar_q;  ir_d = ir_q;  a_d = a_q;  b_d = b_q;
        out_d = out_q;  bus_d = bus_q;  c_d = c_q;  z_d = z_q;
        t_d = t_q;  halted_d = halted_q;
        ram_we = 1'b0;  ram_waddr = mar_q;  ram_wdata = a_q;
        wr = PRGM | WE;
        wval = PRGM ? PRGM_IN : bus_q;
        if (!GO) begin
            if (wr) begin
                case (SEL)
                    4'd0: pc_d  = wval[3:0];
                    4'd1: mar_d = wval[3:0];
                    4'd2: begin ram_we = 1'b1; ram_wdata = wval; end
                    4'd3: ir_d  = wval;
                    4'd4: a_d   = wval;
                    4'd5: b_d   = wval;
                    4'd8: out_d = wval;
                    4'd9: bus_d = wval;
                    default: ;
                endcase
            end else if (OE && SEL != 4'd9) begin
                bus_d = CURRENT;
            end
            if (EN && !HLT && !(wr && SEL == 4'd0))
                pc_d = pc_q + 4'd1;
        end else if (!go_q) begin
            t_d = T0;
            halted_d = 1'b0;
        end else if (!HLT && !halted_q) begin
            case (t_q)
                T0: begin mar_d = pc_q; bus_d = {4'b0, pc_q}; t_d = T1; end
                T1: begin ir_d = ram_rd; bus_d = ram_rd; pc_d = pc_q + 4'd1; t_d = T2; end
                T2: begin
                    t_d = T3;
                    case (opc)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar_d = ir_q[3:0]; bus_d = {4'b0, ir_q[3:0]};
                        end
                        OP_LDI: begin a_d = {4'b0, ir_q[3:0]}; bus_d = {4'b0, ir_q[3:0]}; end
                        OP_JMP: begin pc_d = ir_q[3:0]; bus_d = {4'b0, ir_q[3:0]}; end
                        OP_JC:  if (c_q) begin pc_d = ir_q[3:0]; bus_d = {4'b0, ir_q[3:0]}; end
                        OP_JZ:  if (z_q) begin pc_d = ir_q[3:0]; bus_d = {4'b0, ir_q[3:0]}; end
                        OP_OUT: begin out_d = a_q; bus_d = a_q; end
                        OP_HLT: halted_d = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    t_d = T4;
                    case (opc)
                        OP_LDA:         begin a_d = ram_rd; bus_d = ram_rd; end
                        OP_ADD, OP_SUB: begin b_d = ram_rd; bus_d = ram_rd; end
                        OP_STA:         begin ram_we = 1'b1; bus_d = a_q; end
                        default: ;
                    endcase
                end
                T4: begin
                    t_d = T5;
                    if (opc == OP_ADD || opc == OP_SUB) begin
                        a_d = alu_sum[7:0];
                        bus_d = alu_sum[7:0];
                        c_d = alu_sum[8];
                        z_d = (alu_sum[7:0] == 8'h00);
                    end
                end
                default: t_d = T0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= '0;  mar_q <= '0;  ir_q <= '0;  a_q <= '0;  b_q <= '0;
            out_q <= '0;  bus_q <= '0;  c_q <= 1'b0;  z_q <= 1'b0;
            t_q <= T0;  halted_q <= 1'b0;  go_q <= 1'b0;
        end else begin
            pc_q <= pc_d;  mar_q <= mar_d;  ir_q <= ir_d;  a_q <= a_d;  b_q <= b_d;
            out_q <= out_d;  bus_q <= bus_d;  c_q <= c_d;  z_q <= z_d;
            t_q <= t_d;  halted_q <= halted_d;  go_q <= GO;
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    assign COUNT   = pc_q;
    assign BUS_OUT = bus_q;
    assign ON      = GO & ~HLT & ~halted_q;
endmodule

// File: tb/tb_fpga_computer.sv
// Self-checking bench for fpga_computer: directed front-panel steps plus random programs
// checked against an instruction-level reference interpreter.
module tb_fpga_computer;
    logic       CLK = 1'b0, RESET = 1'b0;
    logic [3:0] SEL = '0;
    logic [7:0] PRGM_IN = '0;
    logic       EN = 1'b0, GO = 1'b0, OE = 1'b0, WE = 1'b0, PRGM = 1'b0, HLT = 1'b0;
    logic [3:0] COUNT;
    logic [7:0] BUS_OUT, CURRENT;
    logic       ON;

    fpga_computer dut (
        .CLK(CLK), .RESET(RESET), .SEL(SEL), .PRGM_IN(PRGM_IN), .EN(EN), .GO(GO),
        .OE(OE), .WE(WE), .PRGM(PRGM), .HLT(HLT),
        .COUNT(COUNT), .BUS_OUT(BUS_OUT), .CURRENT(CURRENT), .ON(ON)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_err = 0;

    // Architectural model state
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out, m_bus;
    logic       m_c, m_z;
    logic [2:0] m_t;
    logic [7:0] m_ram [16];
    logic [7:0] prog [16];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_cur(input logic [3:0] s);
        case (s)
            4'd0:  return {4'h0, m_pc};
            4'd1:  return {4'h0, m_mar};
            4'd2:  return m_ram[m_mar];
            4'd3:  return m_ir;
            4'd4:  return m_a;
            4'd5:  return m_b;
            4'd6:  return (m_ir[7:4] == 4'h3) ? 8'(m_a - m_b) : 8'(m_a + m_b);
            4'd7:  return {6'b0, m_z, m_c};
            4'd8:  return m_out;
            4'd9:  return m_bus;
            4'd10: return {5'b0, m_t};
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic manual(input logic [3:0] s, input logic [7:0] pin,
                          input bit p, input bit w, input bit o, input bit e, input bit h);
        logic [7:0] cur, val;
        bit pcw;
        SEL = s; PRGM_IN = pin; PRGM = p; WE = w; OE = o; EN = e; HLT = h;
        cur = m_cur(s);
        val = p ? pin : m_bus;
        pcw = (p || w) && s == 4'd0;
        tick();
        PRGM = 0; WE = 0; OE = 0; EN = 0; HLT = 0;
        if (p || w) begin
            case (s)
                4'd0: m_pc = val[3:0];
                4'd1: m_mar = val[3:0];
                4'd2: m_ram[m_mar] = val;
                4'd3: m_ir = val;
                4'd4: m_a = val;
                4'd5: m_b = val;
                4'd8: m_out = val;
                4'd9: m_bus = val;
                default: ;
            endcase
        end else if (o && s != 4'd9) m_bus = cur;
        if (e && !h && !pcw) m_pc = m_pc + 4'd1;
        chk("count", {4'h0, COUNT}, {4'h0, m_pc});
        chk("bus", BUS_OUT, m_bus);
        chk("current", CURRENT, m_cur(s));
    endtask

    task automatic check_all(input bit skip_ram);
        for (int s = 0; s < 16; s++) begin
            if (skip_ram && s == 2) continue;
            SEL = 4'(s);
            #1;
            chk($sformatf("sel%0d", s), CURRENT, m_cur(4'(s)));
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            manual(4'd1, 8'(i), 1, 0, 0, 0, 0);
            manual(4'd2, prog[i], 1, 0, 0, 0, 0);
        end
        manual(4'd0, 8'h00, 1, 0, 0, 0, 0);
    endtask

    // Instruction-level interpreter: executes whole instructions until HLT.
    task automatic model_run();
        int steps = 0;
        int s;
        bit hl = 0;
        logic [7:0] ir;
        logic [3:0] x;
        while (!hl && steps < 64) begin
            ir = m_ram[m_pc];
            m_mar = m_pc; m_ir = ir; m_bus = ir; m_pc = m_pc + 4'd1;
            x = ir[3:0];
            steps++;
            case (ir[7:4])
                4'h1: begin m_mar = x; m_a = m_ram[x]; end
                4'h2: begin
                    m_mar = x; m_b = m_ram[x];
                    s = int'(m_a) + int'(m_b);
                    m_a = s[7:0]; m_c = (s > 255); m_z = (m_a == 8'h00);
                end
                4'h3: begin
                    m_mar = x; m_b = m_ram[x];
                    m_c = (m_a >= m_b); m_a = m_a - m_b; m_z = (m_a == 8'h00);
                end
                4'h4: begin m_mar = x; m_ram[x] = m_a; end
                4'h5: m_a = {4'h0, x};
                4'h6: m_pc = x;
                4'h7: if (m_c) m_pc = x;
                4'h8: if (m_z) m_pc = x;
                4'hE: m_out = m_a;
                4'hF: hl = 1;
                default: ;
            endcase
        end
        m_t = 3'd3;
    endtask

    task automatic run_prog(input bit pause);
        int cycles = 0;
        logic [3:0] held;
        GO = 1;
        tick();
        model_run();
        while (ON && cycles < 500) begin
            if (pause && cycles == 4) begin
                HLT = 1;
                #1;
                chk("hlt_on", {7'b0, ON}, 8'h00);
                held = COUNT;
                repeat (4) tick();
                chk("hlt_pc_hold", {4'h0, COUNT}, {4'h0, held});
                HLT = 0;
                #1;
            end
            tick();
            cycles++;
        end
        chk("halted_on", {7'b0, ON}, 8'h00);
        GO = 0;
        tick();
        check_all(0);
    endtask

    initial begin
        {m_pc, m_mar, m_ir, m_a, m_b, m_out, m_bus, m_c, m_z, m_t} = '0;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;

        repeat (2) @(posedge CLK);
        #1 RESET = 1;
        #1;
        chk("rst_count", {4'h0, COUNT}, 8'h00);
        chk("rst_bus", BUS_OUT, 8'h00);
        chk("rst_on", {7'b0, ON}, 8'h00);
        check_all(1);

        manual(4'd9, 8'hAA, 1, 0, 0, 0, 0);
        manual(4'd8, 8'h00, 0, 1, 0, 0, 0);
        chk("t2_out", CURRENT, 8'hAA);
        chk("t2_bus", BUS_OUT, 8'hAA);
        manual(4'd9, 8'h00, 1, 0, 0, 0, 0);
        manual(4'd8, 8'h00, 0, 0, 0, 0, 0);
        chk("t3_bus", BUS_OUT, 8'h00);
        chk("t3_out", CURRENT, 8'hAA);

        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'h05; prog[15] = 8'h03;
        load_prog();
        run_prog(0);
        SEL = 4'd8; #1;
        chk("t4_out", CURRENT, 8'h08);

        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h75; prog[3] = 8'h51;
        prog[4] = 8'hF0; prog[5] = 8'hE0; prog[6] = 8'hF0;
        prog[14] = 8'hFF; prog[15] = 8'h01;
        load_prog();
        run_prog(1);
        SEL = 4'd4; #1; chk("t5_a", CURRENT, 8'h00);
        SEL = 4'd7; #1; chk("t5_flags", CURRENT, 8'h03);
        chk("t5_jc_pc", {4'h0, COUNT}, 8'h07);

        for (int n = 0; n < 6; n++) begin
            logic [3:0] op;
            for (int i = 0; i < 7; i++) begin
                case ($urandom_range(0, 9))
                    0: op = 4'h0;  1: op = 4'h1;  2: op = 4'h2;  3: op = 4'h3;
                    4: op = 4'h4;  5: op = 4'h5;  6: op = 4'h6;  7: op = 4'h7;
                    8: op = 4'h8;  default: op = 4'hE;
                endcase
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: prog[i] = {op, 4'($urandom_range(8, 15))};
                    4'h6, 4'h7, 4'h8:       prog[i] = {op, 4'($urandom_range(i + 1, 7))};
                    default:                prog[i] = {op, 4'($urandom_range(0, 15))};
                endcase
            end
            prog[7] = {4'hF, 4'($urandom_range(0, 15))};
            for (int i = 8; i < 16; i++) prog[i] = 8'($urandom);
            load_prog();
            run_prog(n[0]);
        end

        for (int k = 0; k < 80; k++) begin
            logic [2:0] act;
            act = 3'($urandom_range(0, 5));
            manual(4'($urandom_range(0, 15)), 8'($urandom), act == 0, act == 1, act == 2,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            if (k % 20 == 19) check_all(0);
        end

        manual(4'd0, 8'h00, 1, 0, 0, 0, 0);
        repeat (17) manual(4'd0, 8'h00, 0, 0, 0, 1, 0);
        chk("t6_count", {4'h0, COUNT}, 8'h01);
        repeat (3) manual(4'd0, 8'h00, 0, 0, 0, 1, 1);
        chk("t6_hold", {4'h0, COUNT}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end
endmodule
